// File: rtl/u409_cia_pkg.sv
// Shared types and defaults for the CIA bus-cycle controller and its E clock generator.
package u409_cia_pkg;

  // Default E clock timing, in CLK40 cycles
  localparam int E_DIV_DEF   = 56;
  localparam int E_HIGH_DEF  = 22;
  localparam int RD_LEAD_DEF = 1;

  // Width of a counter spanning 0..div-1 (never narrower than one bit)
  function automatic int ecnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int ECNT_W = ecnt_width(E_DIV_DEF);

  // Bus-cycle controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    TERM   = 2'd3
  } cia_state_e;

endpackage

// File: rtl/u409_eclk_gen.sv
// Free-running E clock generator: phase counter, registered ECLK and the last-phase strobe.
// Kept separate so VPA-style autovector timing can share the same E phase later.
module u409_eclk_gen
  import u409_cia_pkg::*;
#(
  parameter int E_DIV  = E_DIV_DEF,
  parameter int E_HIGH = E_HIGH_DEF,
  localparam int CW    = ecnt_width(E_DIV)
) (
  input  logic          i_clk,
  input  logic          i_srst,
  output logic [CW-1:0] o_ecnt,
  output logic          o_eclk,
  output logic          o_e_last
);

  localparam logic [CW-1:0] LAST     = CW'(E_DIV - 1);
  localparam logic [CW-1:0] HI_START = CW'(E_DIV - E_HIGH);

  logic [CW-1:0] r_ecnt;
  logic          r_eclk;
  logic [CW-1:0] w_ecnt_next;
  logic          w_e_last;

  assign w_e_last    = (r_ecnt == LAST);
  assign w_ecnt_next = w_e_last ? '0 : r_ecnt + CW'(1);

  // Advance the phase counter; ECLK is decoded from the next count so it lines up with ECNT
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_ecnt <= '0;
      r_eclk <= 1'b0;
    end else begin
      r_ecnt <= w_ecnt_next;
      r_eclk <= (w_ecnt_next >= HI_START);
    end
  end

  assign o_ecnt   = r_ecnt;
  assign o_eclk   = r_eclk;
  assign o_e_last = w_e_last;

endmodule

// File: rtl/u409_cia_cycle.sv
// 6800-style synchronous bus cycle sequencer for the two 8520 CIAs on behalf of the 68040.
// A qualified TSn is synchronised to the E phase; the CIA window is one full E period
// starting at the E falling edge, followed by a one-clock TACKn.
module u409_cia_cycle
  import u409_cia_pkg::*;
#(
  parameter int E_DIV   = E_DIV_DEF,
  parameter int E_HIGH  = E_HIGH_DEF,
  parameter int RD_LEAD = RD_LEAD_DEF
) (
  input  logic CLK40,
  input  logic RESET,
  input  logic TSn,
  input  logic CIA_SPACE,
  input  logic RnW,
  output logic ECLK,
  output logic CIA_ENABLE,
  output logic CIA_RnW,
  output logic RD_LATCH,
  output logic TACKn,
  output logic BUSY
);

  localparam int CW = ecnt_width(E_DIV);
  // ECNT one clock before the read strobe, since the strobe is registered
  localparam logic [CW-1:0] RD_PRE = CW'(E_DIV - 2 - RD_LEAD);

  logic [CW-1:0] w_ecnt;
  logic          w_e_last;

  cia_state_e r_state;
  cia_state_e w_state_next;
  logic       r_cia_enable, w_cia_enable_next;
  logic       r_cia_rnw,    w_cia_rnw_next;
  logic       r_rd_latch,   w_rd_latch_next;
  logic       r_tackn,      w_tackn_next;
  logic       r_busy,       w_busy_next;

  u409_eclk_gen #(
    .E_DIV  (E_DIV),
    .E_HIGH (E_HIGH)
  ) u_eclk_gen (
    .i_clk    (CLK40),
    .i_srst   (RESET),
    .o_ecnt   (w_ecnt),
    .o_eclk   (ECLK),
    .o_e_last (w_e_last)
  );

  // Next state and next output values; outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (!TSn && CIA_SPACE) w_state_next = SYNC;
      SYNC:    if (w_e_last)          w_state_next = ACTIVE;
      ACTIVE:  if (w_e_last)          w_state_next = TERM;
      TERM:                           w_state_next = IDLE;
      default:                        w_state_next = IDLE;
    endcase

    w_cia_enable_next = (w_state_next == ACTIVE);
    w_tackn_next      = (w_state_next != TERM);
    w_busy_next       = (w_state_next != IDLE);
    w_rd_latch_next   = (r_state == ACTIVE) && r_cia_rnw && (w_ecnt == RD_PRE);

    // R/W is captured on the way out of IDLE, held through TERM, and parks at read when idle
    if (w_state_next == IDLE) begin
      w_cia_rnw_next = 1'b1;
    end else if (r_state == IDLE) begin
      w_cia_rnw_next = RnW;
    end else begin
      w_cia_rnw_next = r_cia_rnw;
    end
  end

  // State and output registers; reset aborts any cycle in progress without an acknowledge
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_cia_enable <= 1'b0;
      r_cia_rnw    <= 1'b1;
      r_rd_latch   <= 1'b0;
      r_tackn      <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cia_enable <= w_cia_enable_next;
      r_cia_rnw    <= w_cia_rnw_next;
      r_rd_latch   <= w_rd_latch_next;
      r_tackn      <= w_tackn_next;
      r_busy       <= w_busy_next;
    end
  end

  assign CIA_ENABLE = r_cia_enable;
  assign CIA_RnW    = r_cia_rnw;
  assign RD_LATCH   = r_rd_latch;
  assign TACKn      = r_tackn;
  assign BUSY       = r_busy;

endmodule

// File: doc/u409_cia_cycle.md
Name: u409_cia_cycle

Overview:
- Runs 6800-style synchronous bus cycles to the two 8520 CIAs on behalf of the 68040.
- Generates the free-running E clock from CLK40 and detects a CIA access from TSn qualified by the CIA_SPACE decode.
- Drives CIA_ENABLE back into the address decoder, which gates CIACS0n/CIACS1n. Terminates the 040 cycle with a one-clock TACKn.

Parameters:
- E_DIV, 56: CLK40 clocks per E period (about 714 kHz).
- E_HIGH, 22: CLK40 clocks of each E period during which ECLK is high.
- RD_LEAD, 1: clocks before the E falling edge at which RD_LATCH pulses.

Ports:
- CLK40  in  1  system clock, 40 MHz.
- RESET  in  1  synchronous, active-high reset.
- TSn  in  1  68040 transfer start, active low, one clock.
- CIA_SPACE  in  1  from address decode: the current address is in $BFxxxx.
- RnW  in  1  68040 read/write; 1 = read.
- ECLK  out  1  E clock to the CIAs.
- CIA_ENABLE  out  1  to address decode; qualifies CIACS0n/CIACS1n.
- CIA_RnW  out  1  registered R/W presented to the CIAs.
- RD_LATCH  out  1  one-clock strobe to the read data latch.
- TACKn  out  1  transfer acknowledge to the 68040, active low.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- E counter (ECNT):
  - Counts 0..E_DIV-1 and wraps to 0. It runs continuously and is independent of the state machine.
  - ECLK = (ECNT >= E_DIV-E_HIGH), registered. With the defaults ECLK is high for ECNT 34..55.
  - E_LAST = (ECNT == E_DIV-1). The E falling edge coincides with the wrap to 0.
- Reset:
  - ECNT=0, ECLK=0, state=IDLE.
  - CIA_ENABLE=0, CIA_RnW=1, RD_LATCH=0, TACKn=1, BUSY=0.
  - Reset asserted mid-cycle aborts the cycle. No TACKn is issued, and all outputs return to their reset values the following clock.
- States: IDLE, SYNC, ACTIVE, TERM.
- IDLE:
  - When TSn==0 && CIA_SPACE==1 are sampled on a clock edge: capture RnW into CIA_RnW and go to SYNC.
  - Any other TSn is ignored.
- SYNC:
  - Wait until E_LAST, then go to ACTIVE. ACTIVE therefore always begins at ECNT==0.
  - A request sampled in IDLE exactly at E_LAST waits one full extra E period. This is deterministic and intended.
- ACTIVE:
  - CIA_ENABLE=1 for exactly E_DIV clocks (ECNT 0..E_DIV-1).
  - For reads (CIA_RnW=1), RD_LATCH=1 for one clock when ECNT==E_DIV-1-RD_LEAD.
  - On E_LAST go to TERM.
- TERM:
  - Lasts one clock: TACKn=0, CIA_ENABLE=0.
  - CIA_RnW stays at its captured value during TERM and returns to 1 on the exit to IDLE.
  - Go to IDLE.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Latency: from the capture edge to TACKn is between E_DIV+1 and 2*E_DIV+1 clocks, depending on E phase.
- TSn with CIA_SPACE while BUSY is ignored; the 040 never issues one. No queueing.
- CIA_SPACE without TSn never starts a cycle.

Decomposition:
- Package u409_cia_pkg holds:
  - the state enum (IDLE/SYNC/ACTIVE/TERM, 2-bit encoding);
  - default constants for E_DIV, E_HIGH and RD_LEAD;
  - the ECNT width, computed as clog2(E_DIV).
- Sub-module u409_eclk_gen holds ECNT, registered ECLK and the E_LAST strobe. It is reusable later for VPA-style autovector timing.
- The top level holds the FSM and output registers.

Test Plan:
1. Reset check: assert RESET for 3 clocks during ACTIVE -> next clock ECLK=0, CIA_ENABLE=0, TACKn=1, BUSY=0, and ECNT restarts at 0; no TACKn afterwards.
2. Read request: TSn=0, CIA_SPACE=1, RnW=1 sampled at ECNT=10 -> SYNC through ECNT 55; CIA_ENABLE high for 56 clocks from ECNT 0; RD_LATCH pulses once at ECNT 54; TACKn low exactly one clock at the next ECNT 0; then IDLE.
3. Write at boundary: request sampled at ECNT=55, RnW=0 -> one full SYNC period, then ACTIVE; CIA_RnW=0 throughout ACTIVE and TERM; RD_LATCH never pulses; CIA_RnW=1 after TERM.
4. Non-CIA access: TSn=0 with CIA_SPACE=0, then CIA_SPACE=1 with TSn=1 -> BUSY stays 0; no CIA_ENABLE, no TACKn.
5. Request while busy: second TSn+CIA_SPACE pulse during ACTIVE -> ignored; exactly one TACKn.
6. E waveform: free run with defaults -> period 56 clocks, high 22 clocks, starting at ECNT 34; CIA_ENABLE edges always coincide with ECNT wraps.
